im_read_slave: RTL and testbench

//  AXI read-only slave in front of the instruction SRAM. It serves the AR/R channels that the CPU instruction master drives through the interconnect.

---
 rtl/im_read_slave.sv | 120 ++++++++++++
 tb/tb_im_read_slave.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_read_slave.sv
// AXI read-only slave for the instruction SRAM: one INCR/FIXED burst at a time,
// one word per cycle from a 1-cycle-latency SRAM, DECERR/SLVERR for bad requests.
module im_read_slave #(
    parameter int          ID_W    = 8,
    parameter int          LEN_W   = 4,
    parameter int          SRAM_AW = 14,
    parameter logic [31:0] BASE    = 32'h0000_0000
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic [ID_W-1:0]    ARID_S,
    input  logic [31:0]        ARADDR_S,
    input  logic [LEN_W-1:0]   ARLEN_S,
    input  logic [2:0]         ARSIZE_S,
    input  logic [1:0]         ARBURST_S,
    input  logic               ARVALID_S,
    output logic               ARREADY_S,
    output logic [ID_W-1:0]    RID_S,
    output logic [31:0]        RDATA_S,
    output logic [1:0]         RRESP_S,
    output logic               RLAST_S,
    output logic               RVALID_S,
    input  logic               RREADY_S,
    output logic               SRAM_CS,
    output logic               SRAM_OE,
    output logic [SRAM_AW-1:0] SRAM_A,
    input  logic [31:0]        SRAM_DO
);

    typedef enum logic {S_IDLE, S_RDATA} state_t;

    localparam logic [32:0] WIN_BYTES = 33'(1) << (SRAM_AW + 2);

    state_t             r_state, w_state_nxt;
    logic [ID_W-1:0]    r_id;
    logic [SRAM_AW-1:0] r_addr;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_fixed;
    logic [1:0]         r_resp;

    logic               w_ar_hs;
    logic               w_r_hs;
    logic               w_dec;
    logic               w_slv;
    logic [1:0]         w_err;
    logic [SRAM_AW-1:0] w_next_addr;

    assign ARREADY_S = (r_state == S_IDLE) && !ARESET;
    assign RVALID_S  = (r_state == S_RDATA);
    assign RLAST_S   = RVALID_S && (r_cnt == r_len);
    assign RID_S     = r_id;
    assign RRESP_S   = r_resp;
    assign RDATA_S   = (RVALID_S && (r_resp == 2'b00)) ? SRAM_DO : '0;

    assign w_ar_hs = ARVALID_S && ARREADY_S;
    assign w_r_hs  = RVALID_S && RREADY_S;

    // 33-bit compare so a window touching the top of the 4 GiB space cannot overflow
    assign w_dec = ({1'b0, ARADDR_S} < {1'b0, BASE}) ||
                   ({1'b0, ARADDR_S} >= ({1'b0, BASE} + WIN_BYTES));
    assign w_slv = (ARSIZE_S != 3'b010) || (ARADDR_S[1:0] != 2'b00);
    assign w_err = w_dec ? 2'b11 : (w_slv ? 2'b10 : 2'b00);

    assign w_next_addr = r_fixed ? r_addr : r_addr + SRAM_AW'(1);

    always_comb begin
        w_state_nxt = r_state;
        SRAM_CS     = 1'b0;
        SRAM_OE     = 1'b0;
        SRAM_A      = ARADDR_S[SRAM_AW+1:2];
        case (r_state)
            S_IDLE: begin
                if (w_ar_hs) begin
                    w_state_nxt = S_RDATA;
                    SRAM_CS     = 1'b1;
                    SRAM_OE     = 1'b1;
                end
            end
            S_RDATA: begin
                SRAM_CS = !ARESET;
                SRAM_OE = !ARESET;
                // Holding the address under back-pressure keeps SRAM_DO, and thus RDATA, stable
                SRAM_A  = (w_r_hs && !RLAST_S) ? w_next_addr : r_addr;
                if (w_r_hs && RLAST_S) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= S_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_fixed <= 1'b0;
            r_resp  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ar_hs) begin
                r_id    <= ARID_S;
                r_addr  <= ARADDR_S[SRAM_AW+1:2];
                r_len   <= ARLEN_S;
                r_fixed <= (ARBURST_S == 2'b00);
                r_resp  <= w_err;
                r_cnt   <= '0;
            end else if (w_r_hs) begin
                r_cnt <= r_cnt + LEN_W'(1);
                if (!RLAST_S) begin
                    r_addr <= w_next_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_im_read_slave.sv
// Randomized bench for im_read_slave: a beat-queue reference model checked every
// cycle, plus directed reads with literal expected values.
module tb_im_read_slave;

    localparam int ID_W    = 8;
    localparam int LEN_W   = 4;
    localparam int SRAM_AW = 14;
    localparam int DEPTH   = 1 << SRAM_AW;

    logic               ACLK = 1'b0;
    logic               ARESET = 1'b1;
    logic [ID_W-1:0]    ARID_S = '0;
    logic [31:0]        ARADDR_S = '0;
    logic [LEN_W-1:0]   ARLEN_S = '0;
    logic [2:0]         ARSIZE_S = 3'b010;
    logic [1:0]         ARBURST_S = 2'b01;
    logic               ARVALID_S = 1'b0;
    logic               ARREADY_S;
    logic [ID_W-1:0]    RID_S;
    logic [31:0]        RDATA_S;
    logic [1:0]         RRESP_S;
    logic               RLAST_S;
    logic               RVALID_S;
    logic               RREADY_S = 1'b1;
    logic               SRAM_CS;
    logic               SRAM_OE;
    logic [SRAM_AW-1:0] SRAM_A;
    logic [31:0]        SRAM_DO = '0;

    im_read_slave #(
        .ID_W(ID_W), .LEN_W(LEN_W), .SRAM_AW(SRAM_AW), .BASE(32'h0000_0000)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
        .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
        .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S),
        .RLAST_S(RLAST_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .SRAM_CS(SRAM_CS), .SRAM_OE(SRAM_OE), .SRAM_A(SRAM_A), .SRAM_DO(SRAM_DO)
    );

    always #5 ACLK = ~ACLK;

    logic [31:0] mem [DEPTH];

    always @(posedge ACLK) begin
        if (SRAM_CS) SRAM_DO <= mem[SRAM_A];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    bit rr_rand = 1'b0;
    bit rr_val  = 1'b1;

    always @(posedge ACLK) begin
        #1;
        RREADY_S = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
    end

    typedef struct {
        logic [31:0]     data;
        logic [1:0]      resp;
        logic            last;
        logic [ID_W-1:0] id;
    } beat_t;

    beat_t q[$];

    // Expands one accepted request into the full list of beats it must produce
    task automatic push_burst();
        logic [1:0] resp;
        int unsigned word;
        beat_t b;
        if (ARADDR_S >= 32'(4 * DEPTH))                          resp = 2'b11;
        else if (ARSIZE_S != 3'b010 || ARADDR_S[1:0] != 2'b00)   resp = 2'b10;
        else                                                     resp = 2'b00;
        for (int i = 0; i <= int'(ARLEN_S); i++) begin
            word   = ((ARADDR_S >> 2) + ((ARBURST_S == 2'b00) ? 0 : i)) % DEPTH;
            b.data = (resp == 2'b00) ? mem[word] : 32'h0;
            b.resp = resp;
            b.last = (i == int'(ARLEN_S));
            b.id   = ARID_S;
            q.push_back(b);
        end
    endtask

    always @(negedge ACLK) begin
        chk("ARREADY", 32'(ARREADY_S), 32'(!ARESET && q.size() == 0));
        chk("RVALID", 32'(RVALID_S), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("RDATA", RDATA_S, q[0].data);
            chk("RRESP", 32'(RRESP_S), 32'(q[0].resp));
            chk("RLAST", 32'(RLAST_S), 32'(q[0].last));
            chk("RID", 32'(RID_S), 32'(q[0].id));
        end
        if (ARESET)                 q.delete();
        else if (q.size() != 0)     begin if (RREADY_S) void'(q.pop_front()); end
        else if (ARVALID_S)         push_burst();
    end

    task automatic ar(input logic [ID_W-1:0] id, input logic [31:0] addr,
                      input logic [LEN_W-1:0] len, input logic [2:0] size,
                      input logic [1:0] burst);
        int unsigned cyc;
        ARID_S = id; ARADDR_S = addr; ARLEN_S = len; ARSIZE_S = size; ARBURST_S = burst;
        ARVALID_S = 1'b1;
        cyc = 0;
        forever begin
            @(negedge ACLK);
            if (ARREADY_S) break;
            cyc++;
            if (cyc > 200) begin
                n_tests++; n_fail++;
                $display("FAIL ar_timeout: got ARREADY=0 for %0d cycles required 1", cyc);
                ARVALID_S = 1'b0;
                return;
            end
        end
        @(posedge ACLK); #1;
        ARVALID_S = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned cyc = 0;
        forever begin
            @(posedge ACLK); #2;
            if (q.size() == 0) break;
            cyc++;
            if (cyc > 2000) begin
                n_tests++; n_fail++;
                $display("FAIL idle_timeout: got %0d beats pending required 0", q.size());
                break;
            end
        end
    endtask

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    endtask

    initial begin
        #1ms;
        n_fail++;
        $display("FAIL watchdog: got timeout required completion");
        summary();
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[4]     = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) mem[32'h40 + i] = 32'hA000_0040 + 32'(i);
        mem[DEPTH-1] = 32'h7777_0001;
        mem[0]       = 32'h7777_0000;
        mem[8]       = 32'h5555_AAAA;
        mem[32'h20]  = 32'h1234_5678;
        mem[32'h21]  = 32'h9ABC_DEF0;

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("reset_RID", 32'(RID_S), 0);
        chk("reset_RDATA", RDATA_S, 0);
        chk("reset_RRESP", 32'(RRESP_S), 0);
        chk("reset_RLAST", 32'(RLAST_S), 0);
        chk("reset_CS", 32'(SRAM_CS), 0);
        chk("reset_OE", 32'(SRAM_OE), 0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;

        // single read
        ar(8'h12, 32'h10, 4'd0, 3'b010, 2'b01);
        @(negedge ACLK);
        chk("single_RVALID", 32'(RVALID_S), 1);
        chk("single_RDATA", RDATA_S, 32'hDEAD_BEEF);
        chk("single_RLAST", 32'(RLAST_S), 1);
        chk("single_RID", 32'(RID_S), 32'h12);
        chk("single_RRESP", 32'(RRESP_S), 0);
        wait_idle();

        // INCR burst, no bubbles
        ar(8'h01, 32'h100, 4'd3, 3'b010, 2'b01);
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK);
            chk("incr_RDATA", RDATA_S, 32'hA000_0040 + 32'(k));
            chk("incr_RLAST", 32'(RLAST_S), 32'(k == 3));
        end
        @(negedge ACLK);
        chk("incr_ARREADY_after", 32'(ARREADY_S), 1);
        wait_idle();

        // back-pressure on beat 0
        rr_val = 1'b0;
        @(posedge ACLK); #2;
        ar(8'h02, 32'h80, 4'd1, 3'b010, 2'b01);
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            chk("bp_RDATA", RDATA_S, 32'h1234_5678);
            chk("bp_RLAST", 32'(RLAST_S), 0);
        end
        rr_val = 1'b1;
        wait_idle();

        // DECERR just past the window
        ar(8'h03, 32'(4 * DEPTH), 4'd2, 3'b010, 2'b01);
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            chk("dec_RRESP", 32'(RRESP_S), 3);
            chk("dec_RDATA", RDATA_S, 0);
            chk("dec_RLAST", 32'(RLAST_S), 32'(k == 2));
        end
        wait_idle();

        // wrap past the top word
        ar(8'h04, 32'(4 * (DEPTH - 1)), 4'd1, 3'b010, 2'b01);
        @(negedge ACLK); chk("wrap_beat0", RDATA_S, 32'h7777_0001);
        @(negedge ACLK); chk("wrap_beat1", RDATA_S, 32'h7777_0000);
        chk("wrap_RRESP", 32'(RRESP_S), 0);
        wait_idle();

        // FIXED burst repeats one word
        ar(8'h05, 32'h20, 4'd2, 3'b010, 2'b00);
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            chk("fixed_RDATA", RDATA_S, 32'h5555_AAAA);
        end
        wait_idle();

        // SLVERR on wrong size
        ar(8'h06, 32'h40, 4'd0, 3'b001, 2'b01);
        @(negedge ACLK);
        chk("slv_RRESP", 32'(RRESP_S), 2);
        wait_idle();

        // reset during beat 1
        ar(8'h07, 32'h100, 4'd3, 3'b010, 2'b01);
        @(posedge ACLK); #1;
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        chk("rst_RVALID", 32'(RVALID_S), 0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("rst_ARREADY", 32'(ARREADY_S), 1);
        ar(8'h08, 32'h10, 4'd0, 3'b010, 2'b01);
        @(negedge ACLK);
        chk("rst_fresh_RDATA", RDATA_S, 32'hDEAD_BEEF);
        wait_idle();

        // randomized traffic, issued back-to-back with random back-pressure
        rr_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'(4 * DEPTH) + ($urandom & 32'h00FF_FFFC);
                1:       a = ($urandom & 32'(4 * DEPTH - 1)) | 32'(1 + $urandom_range(0, 2));
                2:       a = 32'(4 * DEPTH - 4 * $urandom_range(1, 4));
                default: a = $urandom & 32'(4 * DEPTH - 4);
            endcase
            ar(ID_W'($urandom), a, LEN_W'($urandom),
               ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b010,
               2'($urandom));
        end
        wait_idle();
        rr_rand = 1'b0;
        repeat (2) @(posedge ACLK);

        summary();
        $finish;
    end

endmodule
